fifo_rd_ctrl: RTL

- Read-side drain engine for the asynchronous FIFO. Runs in the FIFO read clock domain.
- Issues rd_en to the FIFO only when it is non-empty and space is guaranteed downstream.
- Absorbs the FIFO's one-cycle registered read latency in a 2-entry skid buffer.
- Presents data as a valid/ready stream framed into fixed-length bursts with a last marker.

---
 rtl/fifo_rd_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side drain engine for an asynchronous FIFO (read clock domain).
//
// Issues rd_en_o only when the FIFO is non-empty and the 2-entry skid buffer is
// guaranteed to have room for the word once the FIFO's one-cycle read latency
// elapses. Buffered words leave as a valid/ready stream framed into bursts of
// BURST_LEN beats, with m_last_o flagging the final beat of each burst.
//
// Optional feature macro: FIFO_RD_CTRL_STATS_EN. When it is defined, the module
// adds the saturating transfer/burst counters word_cnt_o and burst_cnt_o.
//
// Ports:
//   clk_i        read-domain clock (same as the FIFO read clock)
//   rst_i        synchronous reset, active-high
//   enable_i     drain enable
//   empty_i      FIFO empty flag
//   underflow_i  FIFO underflow flag
//   rdata_i      FIFO read data, valid the cycle after rd_en_o=1
//   rd_en_o      FIFO read strobe
//   m_valid_o    stream valid
//   m_ready_i    stream ready
//   m_data_o     stream data (skid buffer head)
//   m_last_o     last beat of a burst
//   busy_o       engine is not idle
//   err_o        sticky protocol error
//   word_cnt_o   (stats only) saturating count of transfers
//   burst_cnt_o  (stats only) saturating count of transfers carrying m_last_o
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int BURST_LEN  = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  empty_i,
    input  logic                  underflow_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  rd_en_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    output logic                  busy_o,
    output logic                  err_o
`ifdef FIFO_RD_CTRL_STATS_EN
    ,
    output logic [15:0]           word_cnt_o,
    output logic [15:0]           burst_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] BEAT_ONE  = CNT_WIDTH'(1);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [DATA_WIDTH-1:0]   buf0_r;
    logic [DATA_WIDTH-1:0]   buf1_r;
    logic [DATA_WIDTH-1:0]   buf0_nxt_s;
    logic [DATA_WIDTH-1:0]   buf1_nxt_s;
    logic [1:0]              cnt_r;
    logic [1:0]              cnt_nxt_s;
    logic                    inflight_r;
    logic [CNT_WIDTH-1:0]    beat_r;
    logic                    err_r;
    logic                    pop_s;
    logic                    cap_s;
    logic                    overflow_s;
    logic [2:0]              occ_s;

    assign m_valid_o = (cnt_r != 2'd0);
    assign m_data_o  = buf0_r;
    assign m_last_o  = m_valid_o & (beat_r == LAST_BEAT);
    assign busy_o    = (state_r != ST_IDLE);
    assign err_o     = err_r;

    assign pop_s = m_valid_o & m_ready_i;
    // The word read last cycle lands on rdata_i now and must be captured.
    assign cap_s = inflight_r;
    assign occ_s = {1'b0, cnt_r} + {2'b00, inflight_r};
    // A capture into a full buffer with no pop to make room; should never happen.
    assign overflow_s = cap_s & ~pop_s & (cnt_r == 2'd2);

    // Read strobe: only issue when the word is guaranteed a slot once it arrives.
    always_comb begin
        rd_en_o = 1'b0;
        if ((state_r == ST_RUN) && !empty_i && ((occ_s - {2'b00, pop_s}) < 3'd2)) begin
            rd_en_o = 1'b1;
        end else begin
            rd_en_o = 1'b0;
        end
    end

    // Next-state logic for the IDLE/RUN/DRAIN controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable_i) state_nxt_s = ST_RUN;
                else          state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (!enable_i) state_nxt_s = ST_DRAIN;
                else           state_nxt_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (enable_i)             state_nxt_s = ST_RUN;
                else if (occ_s == 3'd0)   state_nxt_s = ST_IDLE;
                else                      state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Skid buffer update: head is buf0, capture goes behind the last valid entry.
    always_comb begin
        buf0_nxt_s = buf0_r;
        buf1_nxt_s = buf1_r;
        cnt_nxt_s  = cnt_r;
        case ({cap_s, pop_s})
            2'b01: begin
                buf0_nxt_s = buf1_r;
                cnt_nxt_s  = cnt_r - 2'd1;
            end
            2'b10: begin
                if (cnt_r == 2'd0) begin
                    buf0_nxt_s = rdata_i;
                    cnt_nxt_s  = 2'd1;
                end else if (cnt_r == 2'd1) begin
                    buf1_nxt_s = rdata_i;
                    cnt_nxt_s  = 2'd2;
                end else begin
                    // Full: the word is dropped and overflow_s flags the error.
                    cnt_nxt_s  = cnt_r;
                end
            end
            2'b11: begin
                // Occupancy stays constant; the new word enters behind the survivor.
                if (cnt_r == 2'd1) begin
                    buf0_nxt_s = rdata_i;
                end else begin
                    buf0_nxt_s = buf1_r;
                    buf1_nxt_s = rdata_i;
                end
            end
            default: begin
                cnt_nxt_s = cnt_r;
            end
        endcase
    end

    // State, buffer, beat counter and sticky error registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            buf0_r     <= '0;
            buf1_r     <= '0;
            cnt_r      <= 2'd0;
            inflight_r <= 1'b0;
            beat_r     <= '0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            buf0_r     <= buf0_nxt_s;
            buf1_r     <= buf1_nxt_s;
            cnt_r      <= cnt_nxt_s;
            inflight_r <= rd_en_o;
            err_r      <= err_r | underflow_i | overflow_s;
            if (pop_s) begin
                if (beat_r == LAST_BEAT) beat_r <= '0;
                else                     beat_r <= beat_r + BEAT_ONE;
            end
        end
    end

`ifdef FIFO_RD_CTRL_STATS_EN
    logic [15:0] word_cnt_r;
    logic [15:0] burst_cnt_r;

    assign word_cnt_o  = word_cnt_r;
    assign burst_cnt_o = burst_cnt_r;

    // Saturating transfer and completed-burst counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_cnt_r  <= 16'd0;
            burst_cnt_r <= 16'd0;
        end else begin
            if (pop_s && (word_cnt_r != 16'hFFFF)) begin
                word_cnt_r <= word_cnt_r + 16'd1;
            end
            if (pop_s && m_last_o && (burst_cnt_r != 16'hFFFF)) begin
                burst_cnt_r <= burst_cnt_r + 16'd1;
            end
        end
    end
`endif

endmodule
